// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed seven-segment driver. One of NUM_CHANNELS packed hex
// values is snapshotted at the start of every frame and scanned one digit per
// slot onto shared cathodes and per-digit anodes. Each slot opens with
// BLANK_CYCLES of dark output to suppress ghosting. Leading zeros can be
// suppressed, each digit has its own decimal point, and ACTIVE_LOW selects
// the output polarity.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset (release synchronous to clk)
//   value       packed channels; channel c at [c*NUM_DIGITS*4 +: NUM_DIGITS*4],
//               nibble i is digit i (digit 0 rightmost)
//   chan_sel    channel select; an out-of-range value selects channel 0
//   dp_mask     bit i lights the decimal point of digit i
//   blank_lz    1 = suppress leading zeros
//   seg         segments, seg[0]=a .. seg[6]=g
//   dp          decimal point
//   an          digit anodes, an[i] enables digit i
//   frame_tick  one-cycle pulse at the start of each frame
//
// Parameter constraints: DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) must be >= 2,
// BLANK_CYCLES < DIV, and NUM_DIGITS must be in 1..8.
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int NUM_CHANNELS = 2,
   parameter int CLK_HZ       = 25_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int ACTIVE_LOW   = 1,
   localparam int SEL_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CHANNELS*NUM_DIGITS*4-1:0] value,
   input  logic [SEL_W-1:0]                   chan_sel,
   input  logic [NUM_DIGITS-1:0]              dp_mask,
   input  logic                               blank_lz,
   output logic [6:0]                         seg,
   output logic                               dp,
   output logic [NUM_DIGITS-1:0]              an,
   output logic                               frame_tick
);

   localparam int DIV    = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int SLOT_W = $clog2(DIV);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIG_W  = NUM_DIGITS * 4;

   localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_L  = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

   // Polarity mask: XOR-ing an active-high pattern with it yields the pin
   // level, and the mask itself is the "everything off" level.
   localparam logic POL = (ACTIVE_LOW != 0);
   localparam logic [6:0]            SEG_OFF = {7{POL}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

   // Active-high abcdefg glyphs, a = bit 0.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   logic [SLOT_W-1:0]     slot_cnt;
   logic [IDX_W-1:0]      idx;
   logic [DIG_W-1:0]      snapshot;
   logic [NUM_DIGITS-1:0] dpm_lat;
   logic                  blz_lat;

   logic                  frame_start;
   logic [DIG_W-1:0]      sel_value;
   logic [DIG_W-1:0]      snap_eff;
   logic [NUM_DIGITS-1:0] dpm_eff;
   logic                  blz_eff;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_lz;
   logic                  zero_run;
   logic [NUM_DIGITS-1:0] an_on;

   assign frame_start = (slot_cnt == '0) && (idx == '0);

   // Channel mux; anything that matches no channel falls back to channel 0.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // through the block leaves it unassigned and infers a latch.
      sel_value = value[DIG_W-1:0];
      for (int c = 1; c < NUM_CHANNELS; c++) begin
         if (chan_sel == SEL_W'(c)) sel_value = value[c*DIG_W +: DIG_W];
      end
   end

   // The frame-start cycle already displays the freshly captured values, so
   // the first slot of a frame is consistent even when BLANK_CYCLES is 0.
   assign snap_eff = frame_start ? sel_value : snapshot;
   assign dpm_eff  = frame_start ? dp_mask   : dpm_lat;
   assign blz_eff  = frame_start ? blank_lz  : blz_lat;

   // Pick the current nibble/dp, and decide leading-zero blanking by
   // walking from the most significant digit down: zero_run stays set while
   // every nibble from the top through digit i is zero.
   always_comb begin
      cur_nib  = snap_eff[3:0];
      cur_dp   = dpm_eff[0];
      cur_lz   = 1'b0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (snap_eff[i*4 +: 4] == 4'h0);
         if (idx == IDX_W'(i)) begin
            cur_nib = snap_eff[i*4 +: 4];
            cur_dp  = dpm_eff[i];
            cur_lz  = blz_eff & zero_run & (i != 0);
         end
      end
   end

   assign an_on = NUM_DIGITS'(1) << idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt   <= '0;
         idx        <= '0;
         snapshot   <= '0;
         dpm_lat    <= '0;
         blz_lat    <= 1'b0;
         frame_tick <= 1'b0;
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= POL;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement
         // order.
         if (slot_cnt == SLOT_MAX) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end

         if (frame_start) begin
            snapshot <= sel_value;
            dpm_lat  <= dp_mask;
            blz_lat  <= blank_lz;
         end

         frame_tick <= frame_start;

         // Dark at the head of each slot so the previous digit's segments
         // never bleed onto the next anode.
         if (slot_cnt < BLANK_L) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= POL;
         end else begin
            an  <= an_on ^ AN_OFF;
            seg <= cur_lz ? SEG_OFF : (hex_glyph(cur_nib) ^ SEG_OFF);
            dp  <= cur_dp ^ POL;
         end
      end
   end

endmodule
